// File: rtl/counter_pkg.sv
// Shared types and limits for the parametrised up/down modulo counter.
package counter_pkg;

  typedef enum logic {CNT_WRAP, CNT_SATURATE} count_mode_t;

  localparam int COUNTER_MAX_WIDTH = 32;

endpackage

// File: rtl/counter_updown_mod.sv
// Up/down modulo counter: clear > load > enable > hold, wrap or saturate at the
// range ends, cascade carry on tc and a sticky overflow flag.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int                 WIDTH = 4,
  parameter logic [WIDTH-1:0]   MAX   = {WIDTH{1'b1}},
  parameter count_mode_t        MODE  = CNT_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             tc,
  output logic             overflow
);

  if ((WIDTH < 1) || (WIDTH > COUNTER_MAX_WIDTH) || (MAX == {WIDTH{1'b0}})) begin : g_bad_param
    $error("counter_updown_mod: WIDTH must be 1..%0d and MAX must be 1..2**WIDTH-1",
           COUNTER_MAX_WIDTH);
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             overflow_q;
  logic             overflow_d;
  logic             at_max_s;
  logic             at_min_s;
  logic             tc_s;
  logic [WIDTH-1:0] load_clamped_s;

  // Next-count selection plus the combinational range flags and carry.
  always_comb begin
    count_d        = count_q;
    overflow_d     = overflow_q;
    at_max_s       = (count_q == MAX);
    at_min_s       = (count_q == {WIDTH{1'b0}});
    tc_s           = enable & ~clear & ~load & ((up & at_max_s) | (~up & at_min_s));
    load_clamped_s = (load_value > MAX) ? MAX : load_value;

    if (clear) begin
      count_d    = {WIDTH{1'b0}};
      overflow_d = 1'b0;
    end else if (load) begin
      count_d = load_clamped_s;
    end else if (enable) begin
      // The explicit end-of-range test keeps a MAX below 2**WIDTH-1 from rolling naturally.
      overflow_d = overflow_q | tc_s;
      if (up) begin
        if (!at_max_s) begin
          count_d = count_q + WIDTH'(1'b1);
        end else if (MODE == CNT_SATURATE) begin
          count_d = MAX;
        end else begin
          count_d = {WIDTH{1'b0}};
        end
      end else begin
        if (!at_min_s) begin
          count_d = count_q - WIDTH'(1'b1);
        end else if (MODE == CNT_SATURATE) begin
          count_d = {WIDTH{1'b0}};
        end else begin
          count_d = MAX;
        end
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count and sticky overflow registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= {WIDTH{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;
  assign at_max   = at_max_s;
  assign at_min   = at_min_s;
  assign tc       = tc_s;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: three instances (3-bit/MAX 5 wrap, 3-bit/MAX 5 saturate,
// 4-bit/MAX 15 wrap) share one stimulus stream and are checked against a modulo model.
module tb_counter_updown_mod;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       reset, clear, load, enable, up;
  logic [3:0] lv;
  logic [2:0] cnt0, cnt1;
  logic [3:0] cnt2;
  logic       am0, am1, am2, an0, an1, an2, tc0, tc1, tc2, ov0, ov1, ov2;

  int n_vec = 0;
  int n_err = 0;
  int m_cnt [3];
  bit m_ovf [3];

  always #5 clk = ~clk;

  counter_updown_mod #(.WIDTH(3), .MAX(3'd5), .MODE(CNT_WRAP)) u0 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(lv[2:0]),
    .enable(enable), .up(up), .count(cnt0), .at_max(am0), .at_min(an0), .tc(tc0),
    .overflow(ov0));

  counter_updown_mod #(.WIDTH(3), .MAX(3'd5), .MODE(CNT_SATURATE)) u1 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(lv[2:0]),
    .enable(enable), .up(up), .count(cnt1), .at_max(am1), .at_min(an1), .tc(tc1),
    .overflow(ov1));

  counter_updown_mod #(.WIDTH(4), .MAX(4'd15), .MODE(CNT_WRAP)) u2 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(lv),
    .enable(enable), .up(up), .count(cnt2), .at_max(am2), .at_min(an2), .tc(tc2),
    .overflow(ov2));

  function automatic int mx(int i);
    return (i == 2) ? 15 : 5;
  endfunction

  function automatic int msk(int i);
    return (i == 2) ? 15 : 7;
  endfunction

  function automatic bit is_sat(int i);
    return (i == 1);
  endfunction

  // Range arithmetic straight from the counting rules: modulo for wrap, clamp for saturate.
  function automatic int nxt(int c, int m, bit sat, bit u);
    if (u) return sat ? ((c + 1 > m) ? m : c + 1) : (c + 1) % (m + 1);
    else   return sat ? ((c - 1 < 0) ? 0 : c - 1) : (c + m) % (m + 1);
  endfunction

  function automatic bit exp_tc(int i);
    return enable && !clear && !load &&
           ((up && m_cnt[i] == mx(i)) || (!up && m_cnt[i] == 0));
  endfunction

  function automatic int dut_cnt(int i);
    case (i)
      0: return int'(cnt0);
      1: return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  function automatic int dut_bit(int i, int which);
    logic [3:0] v;
    case (i)
      0: v = {am0, an0, tc0, ov0};
      1: v = {am1, an1, tc1, ov1};
      default: v = {am2, an2, tc2, ov2};
    endcase
    return int'(v[3 - which]);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model state update.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i] <= 0;
        m_ovf[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (clear) begin
          m_cnt[i] <= 0;
          m_ovf[i] <= 1'b0;
        end else if (load) begin
          m_cnt[i] <= ((int'(lv) & msk(i)) > mx(i)) ? mx(i) : (int'(lv) & msk(i));
        end else if (enable) begin
          m_cnt[i] <= nxt(m_cnt[i], mx(i), is_sat(i), up);
          if (exp_tc(i)) m_ovf[i] <= 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("count%0d", i),    dut_cnt(i),    m_cnt[i]);
      chk($sformatf("at_max%0d", i),   dut_bit(i, 0), int'(m_cnt[i] == mx(i)));
      chk($sformatf("at_min%0d", i),   dut_bit(i, 1), int'(m_cnt[i] == 0));
      chk($sformatf("tc%0d", i),       dut_bit(i, 2), int'(exp_tc(i)));
      chk($sformatf("overflow%0d", i), dut_bit(i, 3), int'(m_ovf[i]));
    end
  end

  task automatic setin(bit c, bit l, logic [3:0] v, bit e, bit u);
    clear = c; load = l; lv = v; enable = e; up = u;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    setin(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    chk("reset_count", int'(cnt0), 0);
    chk("reset_ovf", int'(ov0), 0);
    tick();
    tick();
    reset = 1'b1;

    // Asynchronous reset mid-count
    setin(1'b0, 1'b1, 4'd3, 1'b0, 1'b0); tick();
    chk("t1_load3", int'(cnt0), 3);
    setin(1'b0, 1'b0, 4'd0, 1'b1, 1'b1); tick();
    chk("t1_count4", int'(cnt0), 4);
    #1 reset = 1'b0;
    #1;
    chk("t1_async_cnt", int'(cnt0), 0);
    chk("t1_async_ovf", int'(ov0), 0);
    chk("t1_async_cnt2", int'(cnt2), 0);
    tick(); chk("t1_hold_a", int'(cnt0), 0);
    tick(); chk("t1_hold_b", int'(cnt0), 0);
    reset = 1'b1;
    tick(); chk("t1_first", int'(cnt0), 1);

    // Wrap up through MAX
    setin(1'b0, 1'b1, 4'd4, 1'b1, 1'b1); tick();
    setin(1'b0, 1'b0, 4'd0, 1'b1, 1'b1); tick();
    chk("t2_max", int'(cnt0), 5);
    chk("t2_tc", int'(tc0), 1);
    chk("t2_at_max", int'(am0), 1);
    tick();
    chk("t2_wrap", int'(cnt0), 0);
    chk("t2_ovf", int'(ov0), 1);
    chk("t2_sat_hold", int'(cnt1), 5);
    chk("t2_sat_ovf", int'(ov1), 1);
    tick();
    chk("t2_after", int'(cnt0), 1);
    chk("t2_sticky", int'(ov0), 1);

    // Full-range 4-bit wrap
    setin(1'b0, 1'b1, 4'd14, 1'b0, 1'b0); tick();
    chk("t6_clamp", int'(cnt0), 5);
    setin(1'b0, 1'b0, 4'd0, 1'b1, 1'b1); tick();
    chk("t6_w4_max", int'(cnt2), 15);
    tick();
    chk("t6_w4_wrap", int'(cnt2), 0);
    chk("t6_w4_ovf", int'(ov2), 1);

    // Down from zero: wrap vs saturate
    setin(1'b1, 1'b0, 4'd0, 1'b0, 1'b0); tick();
    chk("t3_clr_ovf", int'(ov0), 0);
    setin(1'b0, 1'b0, 4'd0, 1'b1, 1'b0); #1;
    chk("t3_tc_wrap", int'(tc0), 1);
    chk("t3_tc_sat", int'(tc1), 1);
    tick();
    chk("t3_wrap_max", int'(cnt0), 5);
    chk("t3_wrap_ovf", int'(ov0), 1);
    chk("t3_sat_zero", int'(cnt1), 0);
    chk("t3_sat_ovf", int'(ov1), 1);
    for (int k = 0; k < 2; k++) begin
      chk("t3_sat_tc", int'(tc1), 1);
      tick();
      chk("t3_sat_hold", int'(cnt1), 0);
    end

    // Load clamp and priority
    setin(1'b0, 1'b1, 4'd7, 1'b0, 1'b0); tick();
    chk("t4_clamp", int'(cnt0), 5);
    setin(1'b1, 1'b1, 4'd7, 1'b0, 1'b0); tick();
    chk("t4_clr_wins", int'(cnt0), 0);
    setin(1'b0, 1'b1, 4'd2, 1'b1, 1'b0); #1;
    chk("t4_tc_load", int'(tc0), 0);
    tick();
    chk("t4_load_wins", int'(cnt0), 2);

    // Enable low holds while up toggles
    for (int k = 0; k < 3; k++) begin
      setin(1'b0, 1'b0, 4'd0, 1'b0, k[0]); #1;
      chk("t5_tc", int'(tc0), 0);
      tick();
      chk("t5_hold", int'(cnt0), 2);
    end

    // Sticky overflow cleared only by clear
    setin(1'b0, 1'b1, 4'd5, 1'b0, 1'b0); tick();
    setin(1'b0, 1'b0, 4'd0, 1'b1, 1'b1); tick();
    setin(1'b0, 1'b1, 4'd3, 1'b0, 1'b0); tick();
    chk("t6_pre_cnt", int'(cnt0), 3);
    chk("t6_pre_ovf", int'(ov0), 1);
    setin(1'b1, 1'b0, 4'd0, 1'b0, 1'b0); tick();
    chk("t6_clr_cnt", int'(cnt0), 0);
    chk("t6_clr_ovf", int'(ov0), 0);

    // Randomized traffic with occasional mid-cycle resets
    for (int n = 0; n < 600; n++) begin
      setin($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
            4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      tick();
      if ($urandom_range(0, 49) == 0) begin
        #1 reset = 1'b0;
        #1 reset = 1'b1;
      end
    end

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/counter_updown_mod.md
# counter_updown_mod

Parametrised up/down modulo counter with enable, synchronous clear, parallel load, wrap or saturate mode, a cascade carry (`tc`) and a sticky overflow flag. It generalises the lab's basic enabled counter to any width and modulus. Other blocks use it as a timebase, a divider and an event counter. `tc` lets instances chain into multi-digit counters, such as a BCD clock.

## Interface
- `WIDTH`, default 4: counter width in bits; legal values 1..32.
- `MAX`, default (2**WIDTH)-1: terminal value. The count range is 0..MAX, with 1 ≤ MAX ≤ 2**WIDTH-1.
- `MODE`, default `CNT_WRAP`: `counter_pkg::count_mode_t`, either `CNT_WRAP` or `CNT_SATURATE`.

Ports (name, direction, width, meaning):
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset.
- `clear`  input  1  synchronous clear to 0; highest-priority synchronous control.
- `load`  input  1  synchronous parallel load of `load_value`.
- `load_value`  input  WIDTH  value to load; values above MAX clamp to MAX.
- `enable`  input  1  count enable.
- `up`  input  1  direction: 1 counts up, 0 counts down.
- `count`  output  WIDTH  registered count.
- `at_max`  output  1  combinational; asserted when count == MAX.
- `at_min`  output  1  combinational; asserted when count == 0.
- `tc`  output  1  combinational terminal-count / carry-out.
- `overflow`  output  1  registered sticky flag; set on any wrap or saturation hit.

## Operation
- Priority each rising edge is `clear` > `load` > `enable` > hold.
- **clear:** count ← 0 and overflow ← 0.
- **load:** count ← min(load_value, MAX). Overflow is unchanged.
- **enable, up=1:**
  - count < MAX: count ← count+1.
  - count == MAX, WRAP mode: count ← 0.
  - count == MAX, SATURATE mode: count holds at MAX.
- **enable, up=0:**
  - count > 0: count ← count−1.
  - count == 0, WRAP mode: count ← MAX.
  - count == 0, SATURATE mode: count holds at 0.
- **hold:** count is unchanged when enable is low and neither clear nor load is asserted.
- **tc** = enable & ~clear & ~load & ((up & at_max) | (~up & at_min)).
  - This is identical in both modes.
  - For chaining, drive the next stage's `enable` from this stage's `tc`.
- **overflow:** set at the edge where `tc` is high, in both modes. It is cleared only by `clear` or `reset`. If `tc` and `clear` are high in the same cycle, clear wins and overflow = 0. (Since `tc` includes ~clear, `tc` cannot actually be high while `clear` is asserted.)
- **Width arithmetic:** the next value is computed in WIDTH bits. The MAX comparison prevents natural rollover when MAX < 2**WIDTH−1. When MAX == 2**WIDTH−1, the wrap result equals natural rollover.
- **Direction changes:** `up` may change any cycle. Only its value at the edge matters; no extra latency.

## Timing
- Reset values: count = 0 and overflow = 0.
  - Both take effect asynchronously when `reset` falls, with no clock needed.
  - They stay at those values while `reset` is low.
  - The first count happens at the first rising edge after `reset` rises.
- Latency: one cycle from clear/load/enable to `count`.
- `at_max`, `at_min` and `tc` follow `count` and the inputs combinationally in the same cycle.
- Reset mid-operation, including mid-load or while `tc` is high: reset overrides everything, and the pending update is discarded.

## Structure
- Package `counter_pkg` holds:
  - `typedef enum logic {CNT_WRAP, CNT_SATURATE} count_mode_t;`
  - `localparam int COUNTER_MAX_WIDTH = 32;`
- No sub-module. The design is:
  - one `always_comb` for next-count, tc, at_max and at_min;
  - one `always_ff @(posedge clk or negedge reset)` for count and overflow.
- Elaboration-time assertion: MAX in 1..2**WIDTH−1 and WIDTH ≤ COUNTER_MAX_WIDTH.

## Test plan
Bench samples on the negedge of the 10-unit clock, and parameters are WIDTH=3, MAX=5 unless stated.

1. **Async reset:** count=3, enable=1; drive reset=0 two units after a rising edge. Required: count=000 and overflow=0 before the next edge, and count stays 000 for two edges; after reset=1, count is 001 at the next edge.
2. **WRAP up:** from count=4 with enable=1, up=1. Required: count 101 with tc=1 and at_max=1, then count 000 with overflow=1, then count 001 with overflow still 1.
3. **Down / saturate:**
   - WRAP, count=0, up=0, enable=1: next count 101, overflow=1.
   - MODE=CNT_SATURATE, same stimulus: count stays 000 for three edges, tc=1 each cycle, overflow=1.
4. **Load clamp and priority:**
   - load=1, load_value=111: count=101.
   - load=1 and clear=1 in the same cycle: count=000.
   - load=1 with enable=1: tc=0 and the load wins.
5. **Enable low:** count=010, enable=0, toggle `up` every cycle. Required: count holds 010 for three edges and tc=0.
6. **Sticky clear:** overflow=1, count=011; pulse clear. Required: count=000 and overflow=0 after one edge. Also with WIDTH=4, MAX=15 in WRAP mode: counting from 1110 gives 1111, then 0000.
